tx_frame_scheduler: RTL and testbench
=====================================

TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CLOCKS, default 16'd20000: max clocks to wait for a byte's tx_done before abort.
REQ-002 SHALL have parameter INTER_BYTE_GAP, default 8'd2: idle clocks between byte completion and the next tx_start.
REQ-003 SHALL have port clock, input, 1: single clock, all logic on posedge.
REQ-004 SHALL have port reset_n, input, 1: reset is synchronous and active-low.
REQ-005 SHALL have ports req_0 and req_1, input, 1 each: requester frame request, held high until granted.
REQ-006 SHALL have ports frame_0 and frame_1, input, 16 each: frame; [15:8] sent first, [7:0] second.
REQ-007 SHALL have ports grant_0 and grant_1, output, 1 each: one-cycle pulse when that requester's frame is captured.
REQ-008 SHALL have port tx_start, output, 1: one-cycle pulse to the UART transmitter's has_data.
REQ-009 SHALL have port tx_byte, output, 8: byte to the UART transmitter's data input.
REQ-010 SHALL have port tx_active, input, 1: transmitter is_transmitting.
REQ-011 SHALL have port tx_done, input, 1: transmitter completion flag, possibly high more than one cycle.
REQ-012 SHALL have port busy, output, 1: high from grant until frame completion or abort.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse after the second byte completes.
REQ-014 SHALL have port timeout_error, output, 1: one-cycle pulse on abort.

Function
REQ-015 SHALL implement states IDLE, SEND_HI, WAIT_HI, GAP, SEND_LO, WAIT_LO, FINISH.
REQ-016 IDLE: if any req is high, SHALL pick a winner, capture its frame, pulse its grant, set busy, and go to SEND_HI next cycle.
REQ-017 Arbitration SHALL be round-robin on last_winner: with both reqs high, the requester not granted last wins; a single req wins unconditionally.
REQ-018 SEND_HI/SEND_LO SHALL be entered only with tx_active=0 and tx_done=0, and SHALL otherwise stall in place.
REQ-019 On entry, SEND_HI/SEND_LO SHALL drive tx_byte (hi/lo byte), pulse tx_start for exactly one cycle, and go to WAIT_HI/WAIT_LO.
REQ-020 tx_byte SHALL stay stable from the tx_start cycle until the matching tx_done rising edge.
REQ-021 WAIT states SHALL advance only on a tx_done rising edge (tx_done=1, previous sample 0); a multi-cycle high tx_done counts once.
REQ-022 WAIT_HI SHALL go to GAP; GAP SHALL count INTER_BYTE_GAP clocks and go to SEND_LO (INTER_BYTE_GAP=0 means direct).
REQ-023 WAIT_LO SHALL go to FINISH; FINISH SHALL pulse frame_done, clear busy, update last_winner, and go to IDLE.
REQ-024 Each WAIT state SHALL run a 16-bit counter from 0; on reaching TIMEOUT_CLOCKS-1 without done, SHALL pulse timeout_error, clear busy, update last_winner, and go to IDLE; frame_done SHALL NOT pulse.
REQ-025 Requests SHALL be ignored while busy; a req held through a frame SHALL compete at the next IDLE cycle.
REQ-026 Back-to-back: FINISH to the next grant SHALL take exactly 1 clock (IDLE evaluation cycle).
REQ-027 tx_done rising edges outside WAIT states SHALL be ignored.
REQ-028 Frame latency from tx_start(hi) to frame_done SHALL be 2 UART bytes + INTER_BYTE_GAP + 3 control clocks ±1.

Reset
REQ-029 With reset_n=0 at a clock edge, the block SHALL go to IDLE and clear all outputs to 0 (tx_byte=8'h00), counters to 0, and last_winner to 1 (requester 0 wins first).
REQ-030 Reset during a frame SHALL abort it with no frame_done or timeout_error pulse; a UART byte already started completes on its own.
REQ-031 The previous-tx_done sample SHALL reset to 0.

Verification
REQ-032 Single frame: req_0=1, frame_0=16'hA55A, UART_TX model CLOCKS_PER_BIT=4 -> grant_0 pulse, serial bytes 8'hA5 then 8'h5A, one frame_done, busy low after.
REQ-033 Contention: req_0=req_1=1 from reset, frames 16'h1122/16'h3344 -> order 11,22,33,44; then req_0 again first wins only after req_1 is served.
REQ-034 Done stretch: tx_done held high 2 cycles per byte -> exactly 2 bytes sent, no skipped byte, a single frame_done.
REQ-035 Timeout: TIMEOUT_CLOCKS=50, tx_done tied 0 -> timeout_error pulse 50 clocks after tx_start(hi), busy=0, no frame_done, next req granted.
REQ-036 Reset mid-frame: reset_n=0 for 1 clock during WAIT_LO -> all outputs 0 next cycle, no frame_done; new req_1 frame then completes normally.

Source files
------------

// File: rtl/tx_frame_scheduler.sv
// Two-requester frame scheduler: arbitrates round-robin, then feeds the two bytes
// of the granted 16-bit frame to a UART transmitter with gap and timeout handling.
module tx_frame_scheduler #(
    parameter logic [15:0] TIMEOUT_CLOCKS = 16'd20000,
    parameter logic [7:0]  INTER_BYTE_GAP = 8'd2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_0,
    input  logic        req_1,
    input  logic [15:0] frame_0,
    input  logic [15:0] frame_1,
    output logic        grant_0,
    output logic        grant_1,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_error
);

    typedef enum logic [2:0] {
        IDLE, SEND_HI, WAIT_HI, GAP, SEND_LO, WAIT_LO, FINISH
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] frame_reg, frame_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic [7:0]  gap_cnt_reg, gap_cnt_next;
    logic [7:0]  tx_byte_reg, tx_byte_next;
    logic        owner_reg, owner_next;
    logic        last_winner_reg, last_winner_next;
    logic        done_prev_reg;
    logic        grant_0_reg, grant_0_next;
    logic        grant_1_reg, grant_1_next;
    logic        tx_start_reg, tx_start_next;
    logic        busy_reg, busy_next;
    logic        frame_done_reg, frame_done_next;
    logic        timeout_reg, timeout_next;
    logic        winner;
    logic        done_edge;

    // With both requests pending, the one not served last goes next.
    assign winner    = (req_0 && req_1) ? ~last_winner_reg : req_1;
    assign done_edge = tx_done && !done_prev_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            frame_reg       <= 16'h0000;
            wait_cnt_reg    <= 16'h0000;
            gap_cnt_reg     <= 8'h00;
            tx_byte_reg     <= 8'h00;
            owner_reg       <= 1'b0;
            last_winner_reg <= 1'b1;
            done_prev_reg   <= 1'b0;
            grant_0_reg     <= 1'b0;
            grant_1_reg     <= 1'b0;
            tx_start_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            frame_done_reg  <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            frame_reg       <= frame_next;
            wait_cnt_reg    <= wait_cnt_next;
            gap_cnt_reg     <= gap_cnt_next;
            tx_byte_reg     <= tx_byte_next;
            owner_reg       <= owner_next;
            last_winner_reg <= last_winner_next;
            done_prev_reg   <= tx_done;
            grant_0_reg     <= grant_0_next;
            grant_1_reg     <= grant_1_next;
            tx_start_reg    <= tx_start_next;
            busy_reg        <= busy_next;
            frame_done_reg  <= frame_done_next;
            timeout_reg     <= timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        frame_next       = frame_reg;
        wait_cnt_next    = wait_cnt_reg;
        gap_cnt_next     = gap_cnt_reg;
        tx_byte_next     = tx_byte_reg;
        owner_next       = owner_reg;
        last_winner_next = last_winner_reg;
        grant_0_next     = 1'b0;
        grant_1_next     = 1'b0;
        tx_start_next    = 1'b0;
        busy_next        = busy_reg;
        frame_done_next  = 1'b0;
        timeout_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_0 || req_1) begin
                    owner_next   = winner;
                    frame_next   = winner ? frame_1 : frame_0;
                    grant_0_next = ~winner;
                    grant_1_next = winner;
                    busy_next    = 1'b1;
                    state_next   = SEND_HI;
                end
            end
            SEND_HI, SEND_LO: begin
                // Hold off until the transmitter is fully quiet, including a stretched done.
                if (!tx_active && !tx_done) begin
                    tx_byte_next  = (state_reg == SEND_HI) ? frame_reg[15:8] : frame_reg[7:0];
                    tx_start_next = 1'b1;
                    wait_cnt_next = 16'h0000;
                    state_next    = (state_reg == SEND_HI) ? WAIT_HI : WAIT_LO;
                end
            end
            WAIT_HI, WAIT_LO: begin
                if (done_edge) begin
                    gap_cnt_next = 8'h00;
                    if (state_reg == WAIT_LO)
                        state_next = FINISH;
                    else if (INTER_BYTE_GAP == 8'd0)
                        state_next = SEND_LO;
                    else
                        state_next = GAP;
                end else if (wait_cnt_reg == TIMEOUT_CLOCKS - 16'd1) begin
                    timeout_next     = 1'b1;
                    busy_next        = 1'b0;
                    last_winner_next = owner_reg;
                    state_next       = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
            end
            GAP: begin
                if (gap_cnt_reg == INTER_BYTE_GAP - 8'd1)
                    state_next = SEND_LO;
                else
                    gap_cnt_next = gap_cnt_reg + 8'd1;
            end
            FINISH: begin
                frame_done_next  = 1'b1;
                busy_next        = 1'b0;
                last_winner_next = owner_reg;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_0       = grant_0_reg;
    assign grant_1       = grant_1_reg;
    assign tx_start      = tx_start_reg;
    assign tx_byte       = tx_byte_reg;
    assign busy          = busy_reg;
    assign frame_done    = frame_done_reg;
    assign timeout_error = timeout_reg;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Bench for tx_frame_scheduler with a behavioural UART transmitter (4 clocks per bit)
// and a byte scoreboard checked at every tx_start.
module tb_tx_frame_scheduler;
    localparam int BYTE_CLKS = 10 * 4;
    localparam int GAP       = 2;
    localparam int TOUT      = 50;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_0 = 1'b0, req_1 = 1'b0;
    logic [15:0] frame_0 = 16'h0, frame_1 = 16'h0;
    logic        grant_0, grant_1, tx_start, busy, frame_done, timeout_error;
    logic [7:0]  tx_byte;
    logic        tx_active = 1'b0, tx_done = 1'b0;

    int checks = 0;
    int errors = 0;

    tx_frame_scheduler #(.TIMEOUT_CLOCKS(16'd50), .INTER_BYTE_GAP(8'd2)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_0(req_0), .req_1(req_1), .frame_0(frame_0), .frame_1(frame_1),
        .grant_0(grant_0), .grant_1(grant_1),
        .tx_start(tx_start), .tx_byte(tx_byte),
        .tx_active(tx_active), .tx_done(tx_done),
        .busy(busy), .frame_done(frame_done), .timeout_error(timeout_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    logic [7:0] exp_q[$];
    int         grant_q[$];
    int         start_hist[$];
    int         start_cnt = 0, fdone_cnt = 0, tout_cnt = 0, grant_cnt = 0;
    int         fdone_cyc = 0, tout_cyc = 0, grant_cyc = 0;
    int         uart_cnt = 0, done_cnt = 0, done_len = 1;
    bit         uart_mute = 1'b0;
    logic [7:0] held_byte = 8'h00;
    logic [7:0] want;
    logic       done_q = 1'b0;

    // UART transmitter model and output monitor, evaluated mid-cycle.
    always @(negedge clock) begin
        if (grant_0 || grant_1) begin
            grant_q.push_back(grant_1 ? 1 : 0);
            grant_cnt++;
            grant_cyc = cyc;
        end
        if (frame_done) begin fdone_cnt++; fdone_cyc = cyc; end
        if (timeout_error) begin tout_cnt++; tout_cyc = cyc; end
        if (tx_done && !done_q && busy) begin
            checks++;
            if (tx_byte !== held_byte) begin
                errors++;
                $display("FAIL tx_byte_stable got %h want %h", tx_byte, held_byte);
            end
        end
        done_q = tx_done;
        if (tx_start) begin
            start_cnt++;
            start_hist.push_back(cyc);
            held_byte = tx_byte;
            checks++;
            if (tx_active) begin
                errors++;
                $display("FAIL start_while_active got %b want 0", tx_active);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte got %h want none", tx_byte);
            end else begin
                want = exp_q.pop_front();
                if (tx_byte !== want) begin
                    errors++;
                    $display("FAIL byte_order got %h want %h", tx_byte, want);
                end
            end
            $display("byte %h at cycle %0d", tx_byte, cyc);
            tx_active = 1'b1;
            uart_cnt  = BYTE_CLKS;
        end else if (tx_active) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                tx_active = 1'b0;
                if (!uart_mute) done_cnt = done_len;
            end
        end
        tx_done = (done_cnt > 0);
        if (done_cnt > 0) done_cnt--;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        req_0 = 1'b0; req_1 = 1'b0; reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_grant(input int base);
        for (int i = 0; i < 300 && grant_cnt == base; i++) tick();
    endtask

    task automatic wait_end(input int f0, input int t0);
        for (int i = 0; i < 400 && fdone_cnt == f0 && tout_cnt == t0; i++) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
        tick(); tick();
        checks++;
        if ({grant_0, grant_1, tx_start, busy, frame_done, timeout_error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {grant_0, grant_1, tx_start, busy, frame_done, timeout_error});
        end
        checks++;
        if (tx_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx_byte got %h want 00", tx_byte);
        end
        reset_n = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req got busy=%b start=%b want 0 0", busy, tx_start);
        end
        $display("reset checked");
    endtask

    task automatic test_single();
        int g0 = grant_cnt, f0 = fdone_cnt, t0 = tout_cnt, s0 = start_cnt, lat;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        frame_0 = 16'hA55A; req_0 = 1'b1;
        wait_grant(g0);
        req_0 = 1'b0;
        checks++;
        if (grant_cnt != g0 + 1 || grant_q[grant_q.size()-1] != 0) begin
            errors++;
            $display("FAIL single_grant got count %0d want %0d on requester 0", grant_cnt - g0, 1);
        end
        wait_end(f0, t0);
        checks++;
        if (fdone_cnt != f0 + 1) begin
            errors++;
            $display("FAIL single_frame_done got %0d want 1", fdone_cnt - f0);
        end
        checks++;
        if (start_cnt != s0 + 2) begin
            errors++;
            $display("FAIL single_bytes got %0d want 2", start_cnt - s0);
        end else begin
            lat = fdone_cyc - start_hist[s0];
            checks++;
            if (lat < 2*BYTE_CLKS + GAP + 2 || lat > 2*BYTE_CLKS + GAP + 4) begin
                errors++;
                $display("FAIL frame_latency got %0d want %0d+-1", lat, 2*BYTE_CLKS + GAP + 3);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_after got %b want 0", busy);
        end
        $display("single frame A55A done");
    endtask

    task automatic test_contention();
        int g0, f0, t0, q0;
        do_reset();
        g0 = grant_cnt; f0 = fdone_cnt; t0 = tout_cnt; q0 = grant_q.size();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        frame_0 = 16'h1122; frame_1 = 16'h3344;
        req_0 = 1'b1; req_1 = 1'b1;
        wait_grant(g0);
        req_0 = 1'b0; frame_0 = 16'h5566;
        tick();
        req_0 = 1'b1;
        wait_grant(g0 + 1);
        checks++;
        if (grant_cyc - fdone_cyc != 1) begin
            errors++;
            $display("FAIL back_to_back got %0d want 1", grant_cyc - fdone_cyc);
        end
        req_1 = 1'b0;
        wait_grant(g0 + 2);
        req_0 = 1'b0;
        wait_end(f0 + 2, t0);
        checks++;
        if (grant_q.size() != q0 + 3) begin
            errors++;
            $display("FAIL contention_grants got %0d want 3", grant_q.size() - q0);
        end else if (grant_q[q0] != 0 || grant_q[q0+1] != 1 || grant_q[q0+2] != 0) begin
            errors++;
            $display("FAIL contention_order got %0d%0d%0d want 010",
                     grant_q[q0], grant_q[q0+1], grant_q[q0+2]);
        end
        checks++;
        if (fdone_cnt != f0 + 3) begin
            errors++;
            $display("FAIL contention_frames got %0d want 3", fdone_cnt - f0);
        end
        $display("contention order checked");
    endtask

    task automatic test_done_stretch();
        int g0 = grant_cnt, f0 = fdone_cnt, t0 = tout_cnt, s0 = start_cnt;
        done_len = 2;
        exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
        frame_1 = 16'hC33C; req_1 = 1'b1;
        wait_grant(g0);
        req_1 = 1'b0;
        wait_end(f0, t0);
        for (int i = 0; i < 10; i++) tick();
        done_len = 1;
        checks++;
        if (fdone_cnt != f0 + 1 || tout_cnt != t0) begin
            errors++;
            $display("FAIL stretch_frame_done got %0d/%0d want 1/0", fdone_cnt - f0, tout_cnt - t0);
        end
        checks++;
        if (start_cnt != s0 + 2) begin
            errors++;
            $display("FAIL stretch_bytes got %0d want 2", start_cnt - s0);
        end
        $display("done stretch checked");
    endtask

    task automatic test_timeout();
        int g0 = grant_cnt, f0 = fdone_cnt, t0 = tout_cnt, s0 = start_cnt;
        uart_mute = 1'b1;
        exp_q.push_back(8'h77);
        frame_0 = 16'h7788; req_0 = 1'b1;
        wait_grant(g0);
        req_0 = 1'b0;
        wait_end(f0, t0);
        checks++;
        if (tout_cnt != t0 + 1 || start_cnt != s0 + 1) begin
            errors++;
            $display("FAIL timeout_pulse got %0d starts %0d want 1 starts 1", tout_cnt - t0, start_cnt - s0);
        end else begin
            checks++;
            if (tout_cyc - start_hist[s0] != TOUT) begin
                errors++;
                $display("FAIL timeout_delay got %0d want %0d", tout_cyc - start_hist[s0], TOUT);
            end
        end
        checks++;
        if (busy !== 1'b0 || fdone_cnt != f0) begin
            errors++;
            $display("FAIL timeout_cleanup got busy=%b frames=%0d want 0 0", busy, fdone_cnt - f0);
        end
        uart_mute = 1'b0;
        f0 = fdone_cnt; t0 = tout_cnt;
        exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        frame_1 = 16'h1234; req_1 = 1'b1;
        wait_grant(g0 + 1);
        req_1 = 1'b0;
        wait_end(f0, t0);
        checks++;
        if (fdone_cnt != f0 + 1) begin
            errors++;
            $display("FAIL after_timeout_frame got %0d want 1", fdone_cnt - f0);
        end
        $display("timeout checked");
    endtask

    task automatic test_reset_mid();
        int g0 = grant_cnt, f0 = fdone_cnt, t0 = tout_cnt, s0 = start_cnt;
        exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
        frame_0 = 16'hDEAD; req_0 = 1'b1;
        wait_grant(g0);
        req_0 = 1'b0;
        for (int i = 0; i < 300 && start_cnt < s0 + 2; i++) tick();
        tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if ({grant_0, grant_1, tx_start, busy, frame_done, timeout_error} !== 6'b0 || tx_byte !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs got %b %h want 000000 00",
                     {grant_0, grant_1, tx_start, busy, frame_done, timeout_error}, tx_byte);
        end
        for (int i = 0; i < 70; i++) tick();
        checks++;
        if (fdone_cnt != f0 || tout_cnt != t0) begin
            errors++;
            $display("FAIL midreset_no_pulse got %0d/%0d want 0/0", fdone_cnt - f0, tout_cnt - t0);
        end
        exp_q.push_back(8'h0F); exp_q.push_back(8'hF0);
        frame_1 = 16'h0FF0; req_1 = 1'b1;
        wait_grant(g0 + 1);
        req_1 = 1'b0;
        wait_end(f0, t0);
        checks++;
        if (fdone_cnt != f0 + 1) begin
            errors++;
            $display("FAIL after_reset_frame got %0d want 1", fdone_cnt - f0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
        end
        $display("mid-frame reset checked");
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_done_stretch();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got cycle %0d want completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
